peripheral_msi_slave_port_arb: RTL



---
 rtl/peripheral_msi_pkg.sv | 49 ++++
 rtl/peripheral_msi_rr_select.sv | 32 +++
 rtl/peripheral_msi_slave_port_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_msi_pkg.sv
// Shared AHB-Lite encodings, burst-tracker state and helpers for the MSI interconnect.
package peripheral_msi_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int unsigned BEAT_W = 4;
    localparam int unsigned OH_W   = 32;
    localparam int unsigned OH_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } burst_state_e;

    // Beats still to come after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEAT_W-1:0] beats;
        case (hburst)
            HBURST_INCR4, HBURST_WRAP4:   beats = BEAT_W'(3);
            HBURST_INCR8, HBURST_WRAP8:   beats = BEAT_W'(7);
            HBURST_INCR16, HBURST_WRAP16: beats = BEAT_W'(15);
            default:                      beats = '0;
        endcase
        return beats;
    endfunction

    function automatic logic [OH_IDX_W-1:0] onehot_to_idx(input logic [OH_W-1:0] oh);
        logic [OH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < OH_W; i++) begin
            if (oh[i]) idx = idx | OH_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/peripheral_msi_rr_select.sv
// Round-robin pick: first requester strictly after the last grant, wrapping.
module peripheral_msi_rr_select
    import peripheral_msi_pkg::*;
#(
    parameter int unsigned MASTERS = 5
) (
    input  logic [MASTERS-1:0] req,
    input  logic [MASTERS-1:0] last_grant,
    output logic [MASTERS-1:0] next_grant
);

    localparam int unsigned IDX_W = $clog2(MASTERS);

    int unsigned      base;
    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        pos        = '0;
        base       = 32'(onehot_to_idx(OH_W'(last_grant)));
        for (int unsigned k = 1; k <= MASTERS; k++) begin
            pos = IDX_W'((base + k) % MASTERS);
            if (!found && req[pos]) begin
                next_grant[pos] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_msi_slave_port_arb.sv
// AHB-Lite slave-port arbiter: priority then round-robin, burst/lock aware, SEQ-resume fix.
// Optional starvation aging is built when MSI_ARB_AGING_EN is defined.
module peripheral_msi_slave_port_arb
    import peripheral_msi_pkg::*;
#(
    parameter int unsigned PLEN      = 64,
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MASTERS   = 5,
    parameter int unsigned PRIO_BITS = 3,
    parameter int unsigned AGE_LIMIT = 16
) (
    input  logic                                HCLK,
    input  logic                                HRESET,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0]   mstpriority,
    input  logic [MASTERS-1:0]                  mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0]        mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0]        mstHWDATA,
    input  logic [MASTERS-1:0]                  mstHWRITE,
    input  logic [MASTERS-1:0][2:0]             mstHSIZE,
    input  logic [MASTERS-1:0][2:0]             mstHBURST,
    input  logic [MASTERS-1:0][3:0]             mstHPROT,
    input  logic [MASTERS-1:0][1:0]             mstHTRANS,
    input  logic [MASTERS-1:0]                  mstHMASTLOCK,
    input  logic [MASTERS-1:0]                  mstHREADY,
    output logic [XLEN-1:0]                     mstHRDATA,
    output logic                                mstHREADYOUT,
    output logic                                mstHRESP,
    output logic                                slv_HSEL,
    output logic [PLEN-1:0]                     slv_HADDR,
    output logic [XLEN-1:0]                     slv_HWDATA,
    output logic                                slv_HWRITE,
    output logic [2:0]                          slv_HSIZE,
    output logic [2:0]                          slv_HBURST,
    output logic [3:0]                          slv_HPROT,
    output logic [1:0]                          slv_HTRANS,
    output logic                                slv_HMASTLOCK,
    output logic                                slv_HREADYOUT,
    input  logic [XLEN-1:0]                     slv_HRDATA,
    input  logic                                slv_HREADY,
    input  logic                                slv_HRESP,
    output logic [MASTERS-1:0]                  granted_master
);

    localparam int unsigned IDX_W  = $clog2(MASTERS);
    localparam int unsigned LEVELS = 1 << PRIO_BITS;

    logic [MASTERS-1:0]                 grant_q;
    logic [IDX_W-1:0]                   addr_idx_q;
    logic [IDX_W-1:0]                   data_idx_q;
    burst_state_e                       state_q, state_d;
    logic [BEAT_W-1:0]                  beat_q, beat_d;
    logic [LEVELS-1:0][MASTERS-1:0]     last_q;
    logic                               resume_q;

    logic [MASTERS-1:0][PRIO_BITS-1:0]  eff_prio;
    logic [PRIO_BITS-1:0]               req_level;
    logic [MASTERS-1:0]                 level_req;
    logic [MASTERS-1:0]                 rr_grant;
    logic [MASTERS-1:0]                 candidate;
    logic                               switch_c;
    logic [1:0]                         addr_trans;
    logic [2:0]                         addr_burst;
    logic                               addr_lock;

`ifdef MSI_ARB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

    logic [MASTERS-1:0][AGE_W-1:0] age_q;

    // Wait counters keep running through slave wait states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            age_q <= '0;
        end else begin
            for (int i = 0; i < MASTERS; i++) begin
                if (!mstHSEL[i] || grant_q[i]) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AGE_W'(AGE_LIMIT)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            eff_prio[i] = (age_q[i] == AGE_W'(AGE_LIMIT)) ? '1 : mstpriority[i];
        end
    end
`else
    logic [31:0] unused_age_limit;

    // AGE_LIMIT only matters in aging builds.
    assign unused_age_limit = 32'(AGE_LIMIT);
    assign eff_prio         = mstpriority;
`endif

    // Highest requested level and the requesters sitting on it.
    always_comb begin
        req_level = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (mstHSEL[i] && (eff_prio[i] > req_level)) req_level = eff_prio[i];
        end
        level_req = '0;
        for (int i = 0; i < MASTERS; i++) begin
            level_req[i] = mstHSEL[i] && (eff_prio[i] == req_level);
        end
    end

    peripheral_msi_rr_select #(
        .MASTERS    (MASTERS)
    ) u_rr_select (
        .req        (level_req),
        .last_grant (last_q[req_level]),
        .next_grant (rr_grant)
    );

    assign candidate = (|mstHSEL) ? rr_grant : grant_q;

    // A master resuming mid-burst after losing the port restarts as NONSEQ INCR.
    always_comb begin
        addr_trans = mstHTRANS[addr_idx_q];
        addr_burst = mstHBURST[addr_idx_q];
        if (resume_q && (addr_trans == HTRANS_SEQ)) begin
            addr_trans = HTRANS_NONSEQ;
            addr_burst = HBURST_INCR;
        end
    end

    assign addr_lock = mstHMASTLOCK[addr_idx_q];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (slv_HREADY) begin
            if (addr_lock) begin
                state_d = ST_LOCK;
                beat_d  = '0;
            end else begin
                case (state_q)
                    ST_FREE: begin
                        if ((addr_trans == HTRANS_NONSEQ) && (burst_beats(addr_burst) != '0)) begin
                            state_d = ST_BURST;
                            beat_d  = burst_beats(addr_burst);
                        end
                    end
                    ST_BURST: begin
                        if (addr_trans == HTRANS_SEQ) begin
                            beat_d = beat_q - BEAT_W'(1);
                            if (beat_q == BEAT_W'(1)) state_d = ST_FREE;
                        end else if ((addr_trans == HTRANS_IDLE) || (addr_trans == HTRANS_NONSEQ)) begin
                            state_d = ST_FREE;
                            beat_d  = '0;
                        end
                    end
                    ST_LOCK: begin
                        if ((addr_trans == HTRANS_IDLE) ||
                            ((addr_trans == HTRANS_NONSEQ) && (addr_burst == HBURST_SINGLE))) begin
                            state_d = ST_FREE;
                        end
                    end
                    default: begin
                        state_d = ST_FREE;
                        beat_d  = '0;
                    end
                endcase
            end
        end
    end

    // Looking at the next state lets the port move on the edge taking a burst's last beat.
    assign switch_c = slv_HREADY && (state_d == ST_FREE);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q    <= MASTERS'(1);
            addr_idx_q <= '0;
            data_idx_q <= '0;
            state_q    <= ST_FREE;
            beat_q     <= '0;
            resume_q   <= 1'b0;
            for (int l = 0; l < LEVELS; l++) last_q[l] <= MASTERS'(1);
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (slv_HREADY) begin
                data_idx_q <= addr_idx_q;
                resume_q   <= switch_c && (candidate != grant_q);
            end
            if (switch_c) begin
                grant_q           <= candidate;
                last_q[req_level] <= candidate;
                addr_idx_q        <= IDX_W'(onehot_to_idx(OH_W'(candidate)));
            end
        end
    end

    assign slv_HSEL       = mstHSEL[addr_idx_q];
    assign slv_HADDR      = mstHADDR[addr_idx_q];
    assign slv_HWRITE     = mstHWRITE[addr_idx_q];
    assign slv_HSIZE      = mstHSIZE[addr_idx_q];
    assign slv_HPROT      = mstHPROT[addr_idx_q];
    assign slv_HTRANS     = addr_trans;
    assign slv_HBURST     = addr_burst;
    assign slv_HMASTLOCK  = addr_lock;
    assign slv_HREADYOUT  = mstHREADY[addr_idx_q];
    assign slv_HWDATA     = mstHWDATA[data_idx_q];
    assign mstHRDATA      = slv_HRDATA;
    assign mstHREADYOUT   = slv_HREADY;
    assign mstHRESP       = slv_HRESP;
    assign granted_master = grant_q;

endmodule
